wb_host_master: RTL

// Wishbone pipelined initiator: converts one command at a time from a valid/ready command port into a

---
 rtl/wb_host_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_host_master.sv
// rtl/wb_host_master.sv - single-command Wishbone pipelined initiator
// Turns one valid/ready command into one Wishbone cycle and returns data or a timeout error.
module wb_host_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  timeout_hit;

  // The counter value including the current cycle decides the timeout, so the
  // last chance for an ack is the TIMEOUT_CYCLES-th edge after command accept.
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_inc;
        end
        // An ack while the request is still stalled cannot belong to it.
        if (i_wb_ack && (state_q == ST_WAIT || !i_wb_stall)) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_rdata_d = we_q ? '0 : i_wb_data;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (state_q == ST_REQ && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_busy      = busy_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = wdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
